pcie_mem_arbiter: RTL and testbench

- Sits directly downstream of `user_interface`, between it and the single-port frame SRAM.
- Multiplexes two requestors onto one memory port:
  - the FPGA-side user interface: reads, writes and flag updates;
  - the PCIe host: frame upload, result readback and flag polling.
- Owns the 32-bit handshake flag word at `FLAG_ADDR`.
- Returns read data to each requestor in order, tagged by source.

---
 rtl/astro_mem_pkg.sv | 15 +
 rtl/pcie_mem_arbiter_if.sv | 39 +++
 rtl/rd_return_pipe.sv | 42 ++++
 rtl/pcie_mem_arbiter.sv | 74 +++++++
 tb/tb_pcie_mem_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/astro_mem_pkg.sv
// astro_mem_pkg: shared widths, flag address, flag command words and read-return tag type
package astro_mem_pkg;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] FLAG_ADDR = 21'h07FFFE;
  localparam logic [DATA_W-1:0] FLAG_START = 32'h0001_0000;
  localparam logic [DATA_W-1:0] FLAG_ACK = 32'h0000_0002;
  localparam logic [DATA_W-1:0] FLAG_DONE = 32'h0000_0004;
  typedef struct packed {
    logic valid;
    logic src;
    logic bypass;
    logic [DATA_W-1:0] data;
  } rd_tag_t;
endpackage

// File: rtl/pcie_mem_arbiter_if.sv
// pcie_mem_arbiter_if: host, FPGA and SRAM signals seen by the arbiter
interface pcie_mem_arbiter_if #(
  parameter int ADDR_W = astro_mem_pkg::ADDR_W,
  parameter int DATA_W = astro_mem_pkg::DATA_W
);
  logic [ADDR_W-1:0] pci_req_addr;
  logic [DATA_W-1:0] pci_input_data;
  logic pci_wr_en;
  logic pci_rd_en;
  logic [DATA_W-1:0] pci_rd_data;
  logic pci_rd_valid;
  logic pci_overflow;
  logic rd_req;
  logic FPGA_wr_en;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] write_data;
  logic flag_we;
  logic [DATA_W-1:0] out_flag;
  logic rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] in_flag;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input pci_req_addr, pci_input_data, pci_wr_en, pci_rd_en, rd_req, FPGA_wr_en,
          req_addr, write_data, flag_we, out_flag, mem_rdata,
    output pci_rd_data, pci_rd_valid, pci_overflow, rd_ready, rd_data, in_flag,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output pci_req_addr, pci_input_data, pci_wr_en, pci_rd_en, rd_req, FPGA_wr_en,
           req_addr, write_data, flag_we, out_flag, mem_rdata,
    input pci_rd_data, pci_rd_valid, pci_overflow, rd_ready, rd_data, in_flag,
          mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rd_return_pipe.sv
// rd_return_pipe: RD_LAT-deep read tag shift register; last stage steers data to FPGA or host
module rd_return_pipe
  import astro_mem_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  rd_tag_t push_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic rd_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic pci_rd_valid_o,
  output logic [DATA_W-1:0] pci_rd_data_o
);
  rd_tag_t q_q [RD_LAT];
  rd_tag_t cap;
  logic [DATA_W-1:0] rd_q, pci_q, cap_data;
  // data is captured one stage before the last so the registered outputs land at issue+RD_LAT
  if (RD_LAT == 1) begin : g_cap1
    assign cap = push_i;
  end else begin : g_capn
    assign cap = q_q[RD_LAT-2];
  end
  assign cap_data = cap.bypass ? cap.data : mem_rdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) q_q[i] <= '0;
      rd_q <= '0;
      pci_q <= '0;
    end else begin
      q_q[0] <= push_i;
      for (int i = 1; i < RD_LAT; i++) q_q[i] <= q_q[i-1];
      if (cap.valid && cap.src) pci_q <= cap_data;
      if (cap.valid && !cap.src) rd_q <= cap_data;
    end
  end
  assign rd_ready_o = q_q[RD_LAT-1].valid && !q_q[RD_LAT-1].src;
  assign pci_rd_valid_o = q_q[RD_LAT-1].valid && q_q[RD_LAT-1].src;
  assign rd_data_o = rd_q;
  assign pci_rd_data_o = pci_q;
endmodule

// File: rtl/pcie_mem_arbiter.sv
// pcie_mem_arbiter: FPGA-priority arbitration of FPGA and PCIe host onto one SRAM port,
// with a one-entry host pending buffer and the handshake flag register
module pcie_mem_arbiter #(
  parameter int ADDR_W = astro_mem_pkg::ADDR_W,
  parameter int DATA_W = astro_mem_pkg::DATA_W,
  parameter int RD_LAT = 2,
  parameter logic [ADDR_W-1:0] FLAG_ADDR = astro_mem_pkg::FLAG_ADDR
) (
  input logic clk,
  input logic rst,
  pcie_mem_arbiter_if.slave bus
);
  import astro_mem_pkg::*;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  logic [0:0] st_q, st_d;
  logic p_wr_q, p_wr_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d, h_addr;
  logic [DATA_W-1:0] p_data_q, p_data_d, flag_q, flag_d, h_data;
  logic f_go, h_new, pend, h_go, h_wr, h_flag, h_mem, cap;
  rd_tag_t push;
  assign pend = st_q == PEND;
  assign f_go = !rst && (bus.FPGA_wr_en || bus.rd_req);
  assign h_new = bus.pci_wr_en || bus.pci_rd_en;
  // a draining buffer always takes the slot; a new host access alongside it is dropped
  assign h_go = !rst && !f_go && (pend || h_new);
  assign h_wr = pend ? p_wr_q : bus.pci_wr_en;
  assign h_addr = pend ? p_addr_q : bus.pci_req_addr;
  assign h_data = pend ? p_data_q : bus.pci_input_data;
  assign h_flag = h_addr == FLAG_ADDR;
  assign h_mem = h_go && !h_flag;
  assign cap = f_go && h_new && !pend;
  assign st_d = cap ? PEND : (h_go ? IDLE : st_q);
  assign p_wr_d = cap ? bus.pci_wr_en : p_wr_q;
  assign p_addr_d = cap ? bus.pci_req_addr : p_addr_q;
  assign p_data_d = cap ? bus.pci_input_data : p_data_q;
  assign ovf_d = ovf_q || (pend && h_new);
  assign flag_d = bus.flag_we ? bus.out_flag : (h_go && h_wr && h_flag) ? h_data : flag_q;
  assign bus.mem_en = f_go || h_mem;
  assign bus.mem_we = f_go ? bus.FPGA_wr_en : h_mem && h_wr;
  assign bus.mem_addr = f_go ? bus.req_addr : h_mem ? h_addr : '0;
  assign bus.mem_wdata = (f_go && bus.FPGA_wr_en) ? bus.write_data : (h_mem && h_wr) ? h_data : '0;
  assign push = '{valid: (f_go && !bus.FPGA_wr_en) || (h_go && !h_wr), src: !f_go,
                  bypass: h_go && h_flag, data: flag_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      p_wr_q <= 1'b0;
      p_addr_q <= '0;
      p_data_q <= '0;
      flag_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q <= st_d;
      p_wr_q <= p_wr_d;
      p_addr_q <= p_addr_d;
      p_data_q <= p_data_d;
      flag_q <= flag_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.in_flag = flag_q;
  assign bus.pci_overflow = ovf_q;
  rd_return_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .mem_rdata_i(bus.mem_rdata),
    .rd_ready_o(bus.rd_ready),
    .rd_data_o(bus.rd_data),
    .pci_rd_valid_o(bus.pci_rd_valid),
    .pci_rd_data_o(bus.pci_rd_data)
  );
endmodule

// File: tb/tb_pcie_mem_arbiter.sv
// tb_pcie_mem_arbiter: directed scenarios against a small SRAM model with one extra read stage
module tb_pcie_mem_arbiter;
  import astro_mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int errs = 0;
  int wr_cnt = 0;
  logic [31:0] mem [256];
  logic [31:0] rd_q;
  always #5 clk = ~clk;
  pcie_mem_arbiter_if #(.ADDR_W(21), .DATA_W(32)) bus ();
  pcie_mem_arbiter #(.RD_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.mem_rdata = rd_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | i;
      rd_q <= '0;
    end else begin
      if (bus.mem_en && bus.mem_we) begin
        mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.mem_en && !bus.mem_we) rd_q <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic idle();
    bus.pci_req_addr = '0; bus.pci_input_data = '0; bus.pci_wr_en = 0; bus.pci_rd_en = 0;
    bus.rd_req = 0; bus.FPGA_wr_en = 0; bus.req_addr = '0; bus.write_data = '0;
    bus.flag_we = 0; bus.out_flag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); repeat (3) step();
    vec++; if (bus.in_flag !== 32'h0) begin errs++; $display("FAIL reset_in_flag got %h exp 0", bus.in_flag); end
    vec++; if ({bus.rd_ready, bus.pci_rd_valid, bus.pci_overflow} !== 3'b000) begin errs++;
      $display("FAIL reset_valids got %b exp 000", {bus.rd_ready, bus.pci_rd_valid, bus.pci_overflow}); end
    vec++; if (bus.rd_data !== 32'h0) begin errs++; $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); end
    vec++; if (bus.pci_rd_data !== 32'h0) begin errs++; $display("FAIL reset_pci_rd_data got %h exp 0", bus.pci_rd_data); end
    vec++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin errs++;
      $display("FAIL reset_mem_port got %b %b %h %h exp all 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    rst = 0; step();
  endtask

  task automatic test_host_rw();
    bus.pci_wr_en = 1; bus.pci_req_addr = 21'h10; bus.pci_input_data = 32'hA5A5_0001; #1;
    vec++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 21'h10, 32'hA5A5_0001}) begin errs++;
      $display("FAIL host_wr_port got %b%b %h %h exp 11 000010 a5a50001", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    step(); idle();
    bus.pci_rd_en = 1; bus.pci_req_addr = 21'h10; #1;
    vec++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin errs++; $display("FAIL host_rd_port got %b%b exp 10", bus.mem_en, bus.mem_we); end
    step(); idle();
    vec++; if (bus.pci_rd_valid !== 1'b0) begin errs++; $display("FAIL host_rd_early got %b exp 0", bus.pci_rd_valid); end
    step();
    vec++; if ({bus.pci_rd_valid, bus.pci_rd_data} !== {1'b1, 32'hA5A5_0001}) begin errs++;
      $display("FAIL host_rd_return got %b %h exp 1 a5a50001", bus.pci_rd_valid, bus.pci_rd_data); end
    vec++; if (bus.rd_ready !== 1'b0) begin errs++; $display("FAIL host_rd_no_fpga got %b exp 0", bus.rd_ready); end
    step();
    vec++; if (bus.pci_rd_valid !== 1'b0) begin errs++; $display("FAIL host_rd_pulse got %b exp 0", bus.pci_rd_valid); end
  endtask

  task automatic test_flag_collide();
    int wr_before;
    wr_before = wr_cnt;
    bus.pci_wr_en = 1; bus.pci_req_addr = FLAG_ADDR; bus.pci_input_data = FLAG_START;
    bus.flag_we = 1; bus.out_flag = FLAG_ACK; #1;
    vec++; if (bus.mem_en !== 1'b0) begin errs++; $display("FAIL flag_no_sram got %b exp 0", bus.mem_en); end
    step(); idle();
    vec++; if (bus.in_flag !== 32'h2) begin errs++; $display("FAIL flag_fpga_wins got %h exp 2", bus.in_flag); end
    vec++; if (wr_cnt !== wr_before) begin errs++; $display("FAIL flag_sram_writes got %0d exp %0d", wr_cnt, wr_before); end
  endtask

  task automatic test_flag_write_read();
    bus.pci_wr_en = 1; bus.pci_req_addr = FLAG_ADDR; bus.pci_input_data = 32'h7;
    step();
    bus.pci_wr_en = 0; bus.pci_rd_en = 1; #1;
    vec++; if (bus.in_flag !== 32'h7) begin errs++; $display("FAIL flag_host_wr got %h exp 7", bus.in_flag); end
    vec++; if (bus.mem_en !== 1'b0) begin errs++; $display("FAIL flag_rd_bypass got %b exp 0", bus.mem_en); end
    step(); idle(); step();
    vec++; if ({bus.pci_rd_valid, bus.pci_rd_data} !== {1'b1, 32'h7}) begin errs++;
      $display("FAIL flag_rd_return got %b %h exp 1 00000007", bus.pci_rd_valid, bus.pci_rd_data); end
    step();
  endtask

  task automatic test_collision();
    bus.FPGA_wr_en = 1; bus.req_addr = 21'h20; bus.write_data = 32'h1234;
    bus.pci_rd_en = 1; bus.pci_req_addr = 21'h20; #1;
    vec++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 21'h20, 32'h1234}) begin errs++;
      $display("FAIL coll_fpga_first got %b%b %h %h exp 11 000020 00001234", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    step(); idle(); #1;
    vec++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 21'h20}) begin errs++;
      $display("FAIL coll_pend_issue got %b%b %h exp 10 000020", bus.mem_en, bus.mem_we, bus.mem_addr); end
    step();
    vec++; if (bus.pci_rd_valid !== 1'b0) begin errs++; $display("FAIL coll_early got %b exp 0", bus.pci_rd_valid); end
    step();
    vec++; if ({bus.pci_rd_valid, bus.pci_rd_data} !== {1'b1, 32'h1234}) begin errs++;
      $display("FAIL coll_return got %b %h exp 1 00001234", bus.pci_rd_valid, bus.pci_rd_data); end
    vec++; if (bus.pci_overflow !== 1'b0) begin errs++; $display("FAIL coll_no_ovf got %b exp 0", bus.pci_overflow); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      logic e;
      e = c >= 2 && c <= 4;
      vec++; if (bus.rd_ready !== e) begin errs++; $display("FAIL b2b_ready c%0d got %b exp %b", c, bus.rd_ready, e); end
      if (e) begin
        vec++; if (bus.rd_data !== (32'hC000_0000 | 32'(c - 2))) begin errs++;
          $display("FAIL b2b_data c%0d got %h exp %h", c, bus.rd_data, 32'hC000_0000 | 32'(c - 2)); end
      end
      bus.rd_req = c < 3; bus.req_addr = 21'(c);
      step();
    end
    idle();
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 9; c++) begin
      logic e;
      e = c >= 2 && c <= 6;
      vec++; if (bus.rd_ready !== e) begin errs++; $display("FAIL ovf_ready c%0d got %b exp %b", c, bus.rd_ready, e); end
      if (e) begin
        vec++; if (bus.rd_data !== (32'hC000_0000 | 32'(c - 2))) begin errs++;
          $display("FAIL ovf_fpga_data c%0d got %h exp %h", c, bus.rd_data, 32'hC000_0000 | 32'(c - 2)); end
      end
      vec++; if (bus.pci_rd_valid !== (c == 7)) begin errs++; $display("FAIL ovf_host_valid c%0d got %b exp %b", c, bus.pci_rd_valid, c == 7); end
      if (c == 7) begin
        vec++; if (bus.pci_rd_data !== 32'hC000_0040) begin errs++; $display("FAIL ovf_host_data got %h exp c0000040", bus.pci_rd_data); end
      end
      vec++; if (bus.pci_overflow !== (c >= 2)) begin errs++; $display("FAIL ovf_flag c%0d got %b exp %b", c, bus.pci_overflow, c >= 2); end
      bus.rd_req = c < 5; bus.req_addr = 21'(c);
      bus.pci_rd_en = c < 3; bus.pci_req_addr = 21'(32'h40 + c);
      step();
    end
    idle();
  endtask

  task automatic test_mid_reset();
    bus.rd_req = 1; bus.req_addr = 21'h5;
    step(); idle(); rst = 1; #1;
    vec++; if (bus.mem_en !== 1'b0) begin errs++; $display("FAIL mrst_mem_en got %b exp 0", bus.mem_en); end
    step(); rst = 0;
    vec++; if ({bus.rd_ready, bus.pci_rd_valid, bus.pci_overflow} !== 3'b000) begin errs++;
      $display("FAIL mrst_valids got %b exp 000", {bus.rd_ready, bus.pci_rd_valid, bus.pci_overflow}); end
    vec++; if ({bus.in_flag, bus.rd_data, bus.pci_rd_data} !== '0) begin errs++;
      $display("FAIL mrst_regs got %h %h %h exp 0 0 0", bus.in_flag, bus.rd_data, bus.pci_rd_data); end
    step();
    vec++; if ({bus.rd_ready, bus.pci_rd_valid} !== 2'b00) begin errs++;
      $display("FAIL mrst_late got %b exp 00", {bus.rd_ready, bus.pci_rd_valid}); end
  endtask

  initial begin
    idle();
    test_reset();
    test_host_rw();
    test_flag_collide();
    test_flag_write_read();
    test_collision();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
